serial_adder_ctrl: RTL and testbench

//  Bit-serial N-bit adder: one shared half-adder pair (full-adder slice) plus carry flop,

---
 rtl/serial_adder_ctrl.sv | 170 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial W-bit adder.
// A single full-adder slice (two half-adder stages plus a carry flop) is
// stepped over the operands LSB first, one bit per RUN cycle, under a small
// IDLE -> RUN -> DONE state machine with a start/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into A - B (two's complement: inverted B, carry-in of 1).
module serial_adder_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    // One extra counter bit keeps W=1 from wrapping before the compare.
    localparam int               CNT_W    = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_sh_q,  a_sh_d;
    logic [W-1:0]     b_sh_q,  b_sh_d;
    logic [W-1:0]     res_q,   res_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic             b_invert;   // invert B bits entering the slice
    logic             carry_init; // carry loaded on an accepted start
    logic             last_bit;   // this RUN cycle handles the MSB

    // Full-adder slice signals
    logic             slice_a, slice_b;
    logic             ha0_s, ha0_c, ha1_s, ha1_c;
    logic             slice_s, slice_c;
    logic [W-1:0]     res_shift;

`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q, sub_d;
    assign b_invert   = sub_q;
    assign carry_init = sub;
`else
    assign b_invert   = 1'b0;
    assign carry_init = 1'b0;
`endif

    assign last_bit = (cnt_q == LAST_CNT);

    // State and datapath registers; reset clears every flop, mid-op included.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand/result shift registers are reset too, so a reset mid-op leaves nothing stale behind.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Next-state logic: accept start only in IDLE, W RUN cycles, one DONE cycle.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)    state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Full-adder slice from two half-adder stages on the current LSBs.
    always_comb begin
        slice_a   = a_sh_q[0];
        slice_b   = b_sh_q[0] ^ b_invert;
        ha0_s     = slice_a ^ slice_b;
        ha0_c     = slice_a & slice_b;
        ha1_s     = ha0_s ^ carry_q;
        ha1_c     = ha0_s & carry_q;
        slice_s   = ha1_s;
        slice_c   = ha0_c | ha1_c;
        // New sum bit enters at the MSB; after W shifts bit 0 is at position 0.
        res_shift = (res_q >> 1) | (W'(slice_s) << (W - 1));
    end

    // Datapath updates: capture on start, shift while running, publish on last bit.
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = slice_c;
                cnt_d   = cnt_q + CNT_W'(1);
                res_d   = res_shift;
                // Visible result changes only on the way into DONE.
                if (last_bit) begin
                    sum_d  = res_shift;
                    cout_d = slice_c;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; result comes straight from its holding flops.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl -- self-checking bench for serial_adder_ctrl.
// Main instance W=4, second instance W=1. A cycle-level model predicts
// busy/done/sum/cout from the accept edge and plain arithmetic.
// Honours SERIAL_ADDER_SUB_EN when defined.
module tb_serial_adder_ctrl;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         sub   = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         sub1   = 1'b0;
    logic         busy1, done1, cout1;
    logic [0:0]   sum1;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.W(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model (main instance) ----------------
    // e counts rising edges; m_k is the edge that accepted the current op.
    // After edge m_k: W busy cycles, then one done cycle, then idle.
    int e = 0;
    int m_k = 0;
    bit m_act = 1'b0;
    int m_tot = 0;
    int m_pend_sum = 0, m_pend_cout = 0;
    int m_sum = 0, m_cout = 0;
    bit cmp_en = 1'b0;

    always @(posedge clk) begin
        e++;
        if (rst) begin
            m_act  = 1'b0;
            m_sum  = 0;
            m_cout = 0;
        end else if (m_act && (e - m_k) == W) begin
            m_sum  = m_pend_sum;
            m_cout = m_pend_cout;
        end else if ((!m_act || (e - m_k) >= W + 2) && start) begin
            if (sub)
                m_tot = int'(a) + (~int'(b) & MASK) + 1;
            else
                m_tot = int'(a) + int'(b);
            m_pend_sum  = m_tot & MASK;
            m_pend_cout = (m_tot >> W) & 1;
            m_act = 1'b1;
            m_k   = e;
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, (m_act && (e - m_k) < W)  ? 1 : 0);
            check("done", done, (m_act && (e - m_k) == W) ? 1 : 0);
            check("sum",  sum,  m_sum);
            check("cout", cout, m_cout);
        end
    end

`ifndef SERIAL_ADDER_SUB_EN
    // Without the sub port the DUT always adds; keep the model in step.
    initial sub = 1'b0;
`endif

    // ---------------- stimulus helpers ----------------
    // Called at #1 after a rising edge with the DUT idle; returns at #1 after the accept edge.
    task automatic start_op(input int av, input int bv, input bit sv);
        a     = W'(av);
        b     = W'(bv);
        sub   = sv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Waits (bounded) for the done pulse; lat = negedges from the accept edge.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input string name, input int av, input int bv, input bit sv,
                          input int exp_sum, input int exp_cout);
        int lat;
        start_op(av, bv, sv);
        wait_done(lat);
        check({name, "_latency"}, lat, W + 1);
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_cout"}, cout, exp_cout);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct { int av; int bv; int s; int c; } vec_t;
    vec_t vecs[4];

    initial begin
        int n_done;
        int lat;

        vecs[0] = '{av: 7,  bv: 9,  s: 0,  c: 1};
        vecs[1] = '{av: 10, bv: 5,  s: 15, c: 0};
        vecs[2] = '{av: 12, bv: 12, s: 8,  c: 1};
        vecs[3] = '{av: 6,  bv: 3,  s: 9,  c: 0};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_cout", cout, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        cmp_en = 1'b1;
        rst    = 1'b0;
        @(posedge clk);
        #1;

        // 1: 3 + 5, timing and result; model pinned too
        start_op(3, 5, 1'b0);
        wait_done(lat);
        check("t1_latency", lat, 5);
        check("t1_sum", sum, 8);
        check("t1_cout", cout, 0);
        check("t1_model_sum", m_sum, 8);
        @(posedge clk);
        #1;

        // 2: overflow, then carry must not leak into the next op
        run_op("t2a", 15, 1, 1'b0, 0, 1);
        check("t2a_model_cout", m_cout, 1);
        run_op("t2b", 0, 0, 1'b0, 0, 0);

        // Extra add vectors
        foreach (vecs[i]) run_op("vec", vecs[i].av, vecs[i].bv, 1'b0, vecs[i].s, vecs[i].c);

        // 3: second start while busy is ignored
        a = 4'd2; b = 4'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t3_done_count", n_done, 1);
        check("t3_sum", sum, 4);
        check("t3_cout", cout, 0);
        @(posedge clk);
        #1;

        // 4: reset mid-op
        start_op(6, 7, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t4_busy_before", busy, 1);
        @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_sum",  sum,  0);
        check("t4_cout", cout, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t4_no_done", n_done, 0);
        @(posedge clk);
        #1;

`ifdef SERIAL_ADDER_SUB_EN
        // 5: subtract mode
        run_op("t5a", 5, 3, 1'b1, 2, 1);
        run_op("t5b", 3, 5, 1'b1, 14, 0);
        run_op("t5c", 9, 9, 1'b1, 0, 1);
`endif

        // 6: W=1 instance
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        check("t6_busy", busy1, 1);
        check("t6_done_early", done1, 0);
        @(negedge clk);
        check("t6_busy_off", busy1, 0);
        check("t6_done", done1, 1);
        check("t6_sum", sum1, 0);
        check("t6_cout", cout1, 1);
        @(negedge clk);
        check("t6_done_once", done1, 0);
        @(posedge clk);
        #1;
        a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6b_done", done1, 1);
        check("t6b_sum", sum1, 1);
        check("t6b_cout", cout1, 0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
